fetch_line_splitter: RTL and testbench

- Front-end stage directly upstream of the opdecode stage.
- Buffers instruction-cache lines from fetch, splits each line into 32-bit instructions, and presents one instruction per cycle with its PC on pc_out / valid_instr_out / instr_out.
- Handles backpressure, redirect flush, and stops issuing after the 32'hDEAD_BEEF halt word.

---
 rtl/fetch_line_splitter.sv | 130 +++++++++++++
 tb/tb_fetch_line_splitter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_line_splitter.sv
// Fetch line splitter: queues cache lines and issues one 32-bit instruction per cycle.
// Optional macro FETCH_LINE_BYPASS_EN: a line accepted on an empty queue issues next cycle.
module fetch_line_splitter #(
    parameter int XLEN     = 32,
    parameter int CL_SIZE  = 128,
    parameter int Q_LENGTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               line_valid_in,
    input  logic [CL_SIZE-1:0] line_data_in,
    input  logic [XLEN-1:0]    line_pc_in,
    output logic               line_ready_out,
    input  logic               redirect_in,
    input  logic               stall_in,
    output logic [XLEN-1:0]    pc_out,
    output logic               valid_instr_out,
    output logic [XLEN-1:0]    instr_out,
    output logic               halted_out
);
    localparam int W      = CL_SIZE / 32;
    localparam int SLOT_W = $clog2(W);
    localparam int QP_W   = $clog2(Q_LENGTH);
    localparam int CNT_W  = QP_W + 1;
    localparam int HI_W   = XLEN - SLOT_W - 2;
    localparam logic [31:0] HALT_WORD = 32'hDEAD_BEEF;

    logic [CL_SIZE-1:0] r_q_data  [Q_LENGTH];
    logic [HI_W-1:0]    r_q_hi    [Q_LENGTH];
    logic [SLOT_W-1:0]  r_q_start [Q_LENGTH];
    logic [QP_W-1:0]    r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [SLOT_W-1:0]  r_slot;
    logic               r_halted;
    logic               r_vld_p1;
    logic [XLEN-1:0]    r_pc_p1, r_instr_p1;

    logic [SLOT_W-1:0]  w_start_in;
    logic [QP_W-1:0]    w_rd_nxt;
    logic [31:0]        w_head_word, w_out_word;
    logic [HI_W-1:0]    w_out_hi;
    logic [SLOT_W-1:0]  w_out_slot;
    logic               w_empty, w_push, w_enq, w_load, w_pop, w_byp, w_issue;
    logic               w_unused_pc_lsb;

    assign w_unused_pc_lsb = &{1'b0, line_pc_in[1:0]};
    assign w_start_in      = line_pc_in[SLOT_W+1:2];
    assign w_rd_nxt        = r_rd_ptr + QP_W'(1);
    assign w_empty         = (r_count == '0);
    assign line_ready_out  = (r_count < CNT_W'(Q_LENGTH));
    assign w_head_word     = r_q_data[r_rd_ptr][{r_slot, 5'd0} +: 32];

    assign w_push = line_valid_in && line_ready_out && !redirect_in && !r_halted;
    assign w_load = !stall_in && !w_empty && !r_halted && !redirect_in;
    assign w_pop  = w_load && (&r_slot);

`ifdef FETCH_LINE_BYPASS_EN
    // Empty queue: issue straight from the incoming line; a line whose only slot is issued is not kept.
    assign w_byp      = w_push && w_empty && !stall_in;
    assign w_enq      = w_push && !(w_byp && (&w_start_in));
    assign w_out_word = w_byp ? line_data_in[{w_start_in, 5'd0} +: 32] : w_head_word;
    assign w_out_hi   = w_byp ? line_pc_in[XLEN-1:SLOT_W+2] : r_q_hi[r_rd_ptr];
    assign w_out_slot = w_byp ? w_start_in : r_slot;
`else
    assign w_byp      = 1'b0;
    assign w_enq      = w_push;
    assign w_out_word = w_head_word;
    assign w_out_hi   = r_q_hi[r_rd_ptr];
    assign w_out_slot = r_slot;
`endif
    assign w_issue = w_load || w_byp;

    // Stage p0: line queue and slot pointer
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_data[r_wr_ptr]  <= line_data_in;
            r_q_hi[r_wr_ptr]    <= line_pc_in[XLEN-1:SLOT_W+2];
            r_q_start[r_wr_ptr] <= w_start_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_slot   <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + QP_W'(1);
            if (w_pop) r_rd_ptr <= w_rd_nxt;
            if (w_enq && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_enq && w_pop) r_count <= r_count - CNT_W'(1);
            // On pop with a single entry the incoming line (if any) becomes the new head.
            if (w_pop)
                r_slot <= (r_count > CNT_W'(1)) ? r_q_start[w_rd_nxt] : w_start_in;
            else if (w_byp)
                r_slot <= w_start_in + SLOT_W'(1);
            else if (w_load)
                r_slot <= r_slot + SLOT_W'(1);
            else if (w_push && w_empty)
                r_slot <= w_start_in;
        end
    end

    // Stage p1: output register and halt flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1   <= 1'b0;
            r_pc_p1    <= '0;
            r_instr_p1 <= '0;
            r_halted   <= 1'b0;
        end else if (redirect_in) begin
            r_vld_p1 <= 1'b0;
            r_halted <= 1'b0;
        end else if (!stall_in) begin
            r_vld_p1 <= w_issue;
            if (w_issue) begin
                r_pc_p1    <= {w_out_hi, w_out_slot, 2'b00};
                r_instr_p1 <= XLEN'(w_out_word);
                if (w_out_word == HALT_WORD) r_halted <= 1'b1;
            end
        end
    end

    assign pc_out          = r_pc_p1;
    assign instr_out       = r_instr_p1;
    assign valid_instr_out = r_vld_p1;
    assign halted_out      = r_halted;

endmodule

// File: tb/tb_fetch_line_splitter.sv
// Bench for fetch_line_splitter: directed scenarios plus random traffic against a line-queue model.
module tb_fetch_line_splitter;
    localparam int XLEN = 32, CL_SIZE = 128, Q_LENGTH = 4, W = CL_SIZE / 32;
    localparam logic [31:0] HALT = 32'hDEAD_BEEF;

    logic               clk = 1'b0;
    logic               rst, line_valid_in, redirect_in, stall_in;
    logic [CL_SIZE-1:0] line_data_in;
    logic [XLEN-1:0]    line_pc_in;
    logic               line_ready_out, valid_instr_out, halted_out;
    logic [XLEN-1:0]    pc_out, instr_out;

    fetch_line_splitter #(.XLEN(XLEN), .CL_SIZE(CL_SIZE), .Q_LENGTH(Q_LENGTH)) dut (
        .clk(clk), .rst(rst), .line_valid_in(line_valid_in), .line_data_in(line_data_in),
        .line_pc_in(line_pc_in), .line_ready_out(line_ready_out), .redirect_in(redirect_in),
        .stall_in(stall_in), .pc_out(pc_out), .valid_instr_out(valid_instr_out),
        .instr_out(instr_out), .halted_out(halted_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0]    pc;
        logic [CL_SIZE-1:0] data;
        int                 slot;
    } line_t;

    line_t           mq[$];
    logic            m_valid = 1'b0, m_halt = 1'b0;
    logic [XLEN-1:0] m_pc = '0, m_instr = '0;
    logic [XLEN-1:0] got_pc[$], got_instr[$];
    int              errors = 0, checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [CL_SIZE-1:0] d, input int s);
        return d[s*32 +: 32];
    endfunction

    function automatic logic [XLEN-1:0] pc_of(input logic [XLEN-1:0] base, input int s);
        return (base & ~32'(W*4 - 1)) + 32'(s*4);
    endfunction

    task automatic present(inout line_t ln);
        m_pc    = pc_of(ln.pc, ln.slot);
        m_instr = word_of(ln.data, ln.slot);
        m_valid = 1'b1;
        if (m_instr == HALT) m_halt = 1'b1;
        ln.slot = ln.slot + 1;
    endtask

    // Model of one clock edge from the current inputs.
    task automatic model_edge();
        bit    push, taken;
        line_t ln, hd;
        if (rst) begin
            mq.delete(); m_valid = 0; m_halt = 0; m_pc = '0; m_instr = '0;
        end else if (redirect_in) begin
            mq.delete(); m_valid = 0; m_halt = 0;
        end else begin
            push    = line_valid_in && (mq.size() < Q_LENGTH) && !m_halt;
            taken   = 0;
            ln.pc   = line_pc_in;
            ln.data = line_data_in;
            ln.slot = int'((line_pc_in >> 2) % W);
            if (!stall_in) begin
                if (mq.size() > 0 && !m_halt) begin
                    hd = mq.pop_front();
                    present(hd);
                    if (hd.slot < W) mq.push_front(hd);
                end
`ifdef FETCH_LINE_BYPASS_EN
                else if (push && mq.size() == 0) begin
                    present(ln);
                    taken = 1;
                    if (ln.slot < W) mq.push_back(ln);
                end
`endif
                else m_valid = 0;
            end
            if (push && !taken) mq.push_back(ln);
        end
    endtask

    task automatic compare();
        check("valid", 64'(valid_instr_out), 64'(m_valid));
        if (m_valid) begin
            check("pc", 64'(pc_out), 64'(m_pc));
            check("instr", 64'(instr_out), 64'(m_instr));
        end
        check("ready", 64'(line_ready_out), 64'(mq.size() < Q_LENGTH));
        check("halted", 64'(halted_out), 64'(m_halt));
    endtask

    task automatic step();
        if (!rst && !redirect_in && valid_instr_out && !stall_in) begin
            got_pc.push_back(pc_out);
            got_instr.push_back(instr_out);
        end
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic push_line(input logic [XLEN-1:0] pc, input logic [CL_SIZE-1:0] data);
        line_valid_in = 1'b1; line_pc_in = pc; line_data_in = data;
        step();
        line_valid_in = 1'b0;
    endtask

    task automatic check_pcs(input string tag, input logic [XLEN-1:0] base, input int n);
        check({tag, "_count"}, 64'(got_pc.size()), 64'(n));
        for (int i = 0; i < n && i < got_pc.size(); i++)
            check({tag, "_pc"}, 64'(got_pc[i]), 64'(base + 32'(4*i)));
    endtask

    function automatic logic [CL_SIZE-1:0] rand_line();
        logic [31:0] w;
        logic [CL_SIZE-1:0] d;
        d = '0;
        for (int k = 0; k < W; k++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            d[k*32 +: 32] = w;
        end
        return d;
    endfunction

    initial begin
        logic [31:0]        t1_words [4];
        logic [CL_SIZE-1:0] d;
        int                 exp_n;
        t1_words = '{32'h00500093, 32'h00108133, 32'h123452B7, 32'h02208233};

        rst = 1; line_valid_in = 0; redirect_in = 0; stall_in = 0;
        line_data_in = '0; line_pc_in = '0;
        step(); step();
        rst = 0;
        check("rst_pc", 64'(pc_out), 64'h0);
        check("rst_instr", 64'(instr_out), 64'h0);
        check("rst_valid", 64'(valid_instr_out), 64'h0);
        check("rst_ready", 64'(line_ready_out), 64'h1);
        check("rst_halted", 64'(halted_out), 64'h0);

        // Single aligned line
        got_pc.delete(); got_instr.delete();
        push_line(32'h1000, {t1_words[3], t1_words[2], t1_words[1], t1_words[0]});
        repeat (7) step();
        check_pcs("t1", 32'h1000, 4);
        for (int i = 0; i < 4 && i < got_instr.size(); i++)
            check("t1_instr", 64'(got_instr[i]), 64'(t1_words[i]));

        // Line entered mid-way
        got_pc.delete(); got_instr.delete();
        push_line(32'h2008, rand_line());
        repeat (5) step();
        check_pcs("t2", 32'h2008, 2);

        // Fill the queue under stall, then drain
        got_pc.delete(); got_instr.delete();
        stall_in = 1;
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < W; k++) d[k*32 +: 32] = 32'h4000_0000 | 32'(l << 8) | 32'(k);
            push_line(32'h4000 + 32'(l*16), d);
        end
        check("t3_ready_full", 64'(line_ready_out), 64'h0);
        push_line(32'h4040, rand_line());
        stall_in = 0;
        repeat (20) step();
        check_pcs("t3", 32'h4000, 16);
        for (int i = 0; i < 16 && i < got_instr.size(); i++)
            check("t3_instr", 64'(got_instr[i]), 64'(32'h4000_0000 | 32'((i/4) << 8) | 32'(i%4)));

        // Stall mid-line
        got_pc.delete(); got_instr.delete();
        push_line(32'h5000, rand_line());
        step(); step();
        stall_in = 1;
        repeat (3) step();
        stall_in = 0;
        repeat (5) step();
        check_pcs("t4", 32'h5000, 4);

        // Halt word in slot 1, then redirect and restart
        got_pc.delete(); got_instr.delete();
        d = rand_line();
        d[63:32] = HALT;
        push_line(32'h6000, d);
        repeat (3) step();
        push_line(32'h6100, rand_line());
        repeat (3) step();
        check("t5_halted", 64'(halted_out), 64'h1);
        check("t5_valid", 64'(valid_instr_out), 64'h0);
        check_pcs("t5", 32'h6000, 2);
        redirect_in = 1; step(); redirect_in = 0;
        check("t5_unhalt", 64'(halted_out), 64'h0);
        got_pc.delete(); got_instr.delete();
        push_line(32'h3000, rand_line());
        repeat (6) step();
        check_pcs("t5b", 32'h3000, 4);

        // Redirect with lines queued and a concurrent line
        got_pc.delete(); got_instr.delete();
        push_line(32'h8000, rand_line());
        push_line(32'h8010, rand_line());
        line_valid_in = 1; line_pc_in = 32'h8020; line_data_in = rand_line();
        redirect_in = 1; stall_in = 1;
        step();
        line_valid_in = 0; redirect_in = 0; stall_in = 0;
        check("t6_valid", 64'(valid_instr_out), 64'h0);
        check("t6_ready", 64'(line_ready_out), 64'h1);
        repeat (5) step();
`ifdef FETCH_LINE_BYPASS_EN
        exp_n = 1;
`else
        exp_n = 0;
`endif
        check("t6_count", 64'(got_pc.size()), 64'(exp_n));

        // First-issue latency on an empty queue
        push_line(32'h7004, rand_line());
`ifdef FETCH_LINE_BYPASS_EN
        check("t7_valid_n1", 64'(valid_instr_out), 64'h1);
        check("t7_pc_n1", 64'(pc_out), 64'h7004);
`else
        check("t7_valid_n1", 64'(valid_instr_out), 64'h0);
        step();
        check("t7_valid_n2", 64'(valid_instr_out), 64'h1);
        check("t7_pc_n2", 64'(pc_out), 64'h7004);
`endif
        repeat (5) step();

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            line_valid_in = ($urandom_range(0, 2) != 0);
            line_pc_in    = 32'h0001_0000 + 32'($urandom_range(0, 255) << 2);
            line_data_in  = rand_line();
            stall_in      = ($urandom_range(0, 3) == 0);
            redirect_in   = ($urandom_range(0, 39) == 0);
            step();
        end
        line_valid_in = 0; stall_in = 0; redirect_in = 0;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
